// File: rtl/dkong_rom_arb.sv
// dkong_rom_arb: shares one external ROM port between the main CPU, the
// sound CPU and the wave player. Each requester gets a one-deep pending
// slot; CPU has fixed priority, SND and WAV alternate round-robin.
// Ports: I_CLK_24576M clock, I_RESETn async active-low reset;
//   CPU/SND/WAV: *_REQ, *_A in, *_DO, *_ACK out;
//   memory: O_MEM_A, O_MEM_RD out, I_MEM_RDY, I_MEM_DO in;
//   O_TMO_ERR sticky memory-ready timeout flag.
// Optional: define DKONG_ROM_ARB_TIMEOUT_EN to abort a WAIT after TMO_CYC
//   clocks with data 8'hFF; otherwise WAIT holds until ready.
module dkong_rom_arb #(
    parameter int TMO_CYC = 15
) (
    input  logic        I_CLK_24576M,
    input  logic        I_RESETn,
    input  logic        I_CPU_REQ,
    input  logic [15:0] I_CPU_A,
    output logic [7:0]  O_CPU_DO,
    output logic        O_CPU_ACK,
    input  logic        I_SND_REQ,
    input  logic [11:0] I_SND_A,
    output logic [7:0]  O_SND_DO,
    output logic        O_SND_ACK,
    input  logic        I_WAV_REQ,
    input  logic [18:0] I_WAV_A,
    output logic [7:0]  O_WAV_DO,
    output logic        O_WAV_ACK,
    output logic [19:0] O_MEM_A,
    output logic        O_MEM_RD,
    input  logic        I_MEM_RDY,
    input  logic [7:0]  I_MEM_DO,
    output logic        O_TMO_ERR
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [2:0] G_CPU = 3'b001;
    localparam logic [2:0] G_SND = 3'b010;
    localparam logic [2:0] G_WAV = 3'b100;

    state_t      state_q, state_d;
    logic [2:0]  gnt_q, gnt_d;
    logic        snd_next_q, snd_next_d;
    logic [2:0]  pend_q;
    logic [15:0] cpu_a_q;
    logic [11:0] snd_a_q;
    logic [18:0] wav_a_q;
    logic [2:0]  ack_q;
    logic [7:0]  cpu_do_q, snd_do_q, wav_do_q;
    logic        tmo_hit;
    logic        done_go;
    logic [7:0]  rd_data;
    logic [19:0] mem_a;

`ifdef DKONG_ROM_ARB_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);

    logic [7:0] tmo_cnt_q;
    logic       tmo_err_q;

    // Counts WAIT cycles already spent; fires in the TMO_CYC-th one.
    assign tmo_hit = (state_q == WAIT) && !I_MEM_RDY &&
                     (tmo_cnt_q == TMO_LAST);

    always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
        if (!I_RESETn) begin
            tmo_cnt_q <= 8'h00;
            tmo_err_q <= 1'b0;
        end else begin
            if (state_q == WAIT) tmo_cnt_q <= tmo_cnt_q + 8'h01;
            else                 tmo_cnt_q <= 8'h00;
            if (tmo_hit) tmo_err_q <= 1'b1;
        end
    end

    assign O_TMO_ERR = tmo_err_q;
`else
    // TMO_CYC only matters when the timeout is built in.
    logic unused_tmo;
    assign unused_tmo = (TMO_CYC != 0);
    assign tmo_hit    = 1'b0;
    assign O_TMO_ERR  = 1'b0;
`endif

    assign done_go = (state_q == WAIT) && (I_MEM_RDY || tmo_hit);
    assign rd_data = tmo_hit ? 8'hFF : I_MEM_DO;

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        snd_next_d = snd_next_q;
        case (state_q)
            IDLE: begin
                if (|pend_q) begin
                    state_d = ISSUE;
                    if (pend_q[0]) begin
                        gnt_d = G_CPU;
                    end else if (pend_q[1] && (!pend_q[2] || snd_next_q)) begin
                        gnt_d      = G_SND;
                        snd_next_d = 1'b0;
                    end else begin
                        gnt_d      = G_WAV;
                        snd_next_d = 1'b1;
                    end
                end
            end
            ISSUE:   state_d = WAIT;
            WAIT:    if (I_MEM_RDY || tmo_hit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
        if (!I_RESETn) begin
            state_q    <= IDLE;
            gnt_q      <= 3'b000;
            snd_next_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            snd_next_q <= snd_next_d;
        end
    end

    // A port stays pending through its own service, so a REQ seen while
    // pending or in DONE is dropped rather than queued.
    always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
        if (!I_RESETn) begin
            pend_q   <= 3'b000;
            cpu_a_q  <= 16'h0000;
            snd_a_q  <= 12'h000;
            wav_a_q  <= 19'h00000;
            ack_q    <= 3'b000;
            cpu_do_q <= 8'h00;
            snd_do_q <= 8'h00;
            wav_do_q <= 8'h00;
        end else begin
            ack_q <= 3'b000;
            if (done_go) begin
                ack_q <= gnt_q;
                if (gnt_q[0]) cpu_do_q <= rd_data;
                if (gnt_q[1]) snd_do_q <= rd_data;
                if (gnt_q[2]) wav_do_q <= rd_data;
            end
            if (state_q == DONE && gnt_q[0]) begin
                pend_q[0] <= 1'b0;
            end else if (I_CPU_REQ && !pend_q[0]) begin
                pend_q[0] <= 1'b1;
                cpu_a_q   <= I_CPU_A;
            end
            if (state_q == DONE && gnt_q[1]) begin
                pend_q[1] <= 1'b0;
            end else if (I_SND_REQ && !pend_q[1]) begin
                pend_q[1] <= 1'b1;
                snd_a_q   <= I_SND_A;
            end
            if (state_q == DONE && gnt_q[2]) begin
                pend_q[2] <= 1'b0;
            end else if (I_WAV_REQ && !pend_q[2]) begin
                pend_q[2] <= 1'b1;
                wav_a_q   <= I_WAV_A;
            end
        end
    end

    always_comb begin
        mem_a = 20'h00000;
        unique case (1'b1)
            gnt_q[0]: mem_a = {4'h0, cpu_a_q};
            gnt_q[1]: mem_a = {8'h10, snd_a_q};
            gnt_q[2]: mem_a = {1'b1, wav_a_q};
            default:  mem_a = 20'h00000;
        endcase
    end

    assign O_MEM_RD  = (state_q == ISSUE) || (state_q == WAIT);
    assign O_MEM_A   = O_MEM_RD ? mem_a : 20'h00000;
    assign O_CPU_ACK = ack_q[0];
    assign O_SND_ACK = ack_q[1];
    assign O_WAV_ACK = ack_q[2];
    assign O_CPU_DO  = cpu_do_q;
    assign O_SND_DO  = snd_do_q;
    assign O_WAV_DO  = wav_do_q;

endmodule

// File: tb/tb_dkong_rom_arb.sv
// tb_dkong_rom_arb: randomized self-checking bench for dkong_rom_arb.
// A transaction-level timeline model predicts ACK cycles, data and addresses.
module tb_dkong_rom_arb;

    localparam int TMO  = 15;
    localparam int MAXC = 512;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        I_CPU_REQ = 1'b0, I_SND_REQ = 1'b0, I_WAV_REQ = 1'b0;
    logic [15:0] I_CPU_A = '0;
    logic [11:0] I_SND_A = '0;
    logic [18:0] I_WAV_A = '0;
    logic [7:0]  O_CPU_DO, O_SND_DO, O_WAV_DO;
    logic        O_CPU_ACK, O_SND_ACK, O_WAV_ACK;
    logic [19:0] O_MEM_A;
    logic        O_MEM_RD;
    logic        I_MEM_RDY = 1'b0;
    logic [7:0]  I_MEM_DO = '0;
    logic        O_TMO_ERR;

    dkong_rom_arb #(.TMO_CYC(TMO)) dut (
        .I_CLK_24576M(clk), .I_RESETn(rst_n),
        .I_CPU_REQ(I_CPU_REQ), .I_CPU_A(I_CPU_A),
        .O_CPU_DO(O_CPU_DO), .O_CPU_ACK(O_CPU_ACK),
        .I_SND_REQ(I_SND_REQ), .I_SND_A(I_SND_A),
        .O_SND_DO(O_SND_DO), .O_SND_ACK(O_SND_ACK),
        .I_WAV_REQ(I_WAV_REQ), .I_WAV_A(I_WAV_A),
        .O_WAV_DO(O_WAV_DO), .O_WAV_ACK(O_WAV_ACK),
        .O_MEM_A(O_MEM_A), .O_MEM_RD(O_MEM_RD),
        .I_MEM_RDY(I_MEM_RDY), .I_MEM_DO(I_MEM_DO),
        .O_TMO_ERR(O_TMO_ERR)
    );

    always #20 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        int         cyc;
        logic [1:0] port;
        logic [7:0] data;
    } ev_t;

    ev_t         exp_q[$], act_q[$];
    logic [19:0] exp_a[$], act_a[$];
    int          dly_q[$];
    int          force_do = -1;
    bit          sreq [3][MAXC];
    logic [18:0] saddr [3][MAXC];
    bit          m_snd_next = 1'b1;
    int          n_chk = 0, n_fail = 0;
    int          glitch = 0;
    int          sched_base = 0;

    function automatic logic [19:0] map(int p, logic [18:0] a);
        case (p)
            0:       return {4'h0, a[15:0]};
            1:       return {8'h10, a[11:0]};
            default: return {1'b1, a};
        endcase
    endfunction

    function automatic logic [7:0] mdata(logic [19:0] a);
        if (force_do >= 0) return 8'(force_do);
        return a[7:0] ^ a[15:8] ^ {4'h0, a[19:16]} ^ 8'h3C;
    endfunction

    // Memory: ready in the w-th WAIT cycle, random noise elsewhere.
    initial begin : responder
        int rd_cnt, cur_w;
        rd_cnt = 0;
        cur_w  = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rd_cnt    = 0;
                I_MEM_RDY = 1'b0;
            end else if (O_MEM_RD) begin
                rd_cnt++;
                if (rd_cnt == 1) begin
                    cur_w = (dly_q.size() > 0) ? dly_q.pop_front() : 100000;
                    I_MEM_RDY = 1'($urandom_range(0, 1));
                    I_MEM_DO  = 8'($urandom);
                end else begin
                    I_MEM_RDY = (rd_cnt == cur_w + 1);
                    I_MEM_DO  = I_MEM_RDY ? mdata(O_MEM_A) : 8'($urandom);
                end
            end else begin
                rd_cnt    = 0;
                I_MEM_RDY = 1'($urandom_range(0, 1));
                I_MEM_DO  = 8'($urandom);
            end
        end
    end

    initial begin : monitor
        logic [7:0]  pdo [3];
        logic [19:0] pa;
        bit          prd;
        pdo[0] = '0; pdo[1] = '0; pdo[2] = '0;
        pa = '0; prd = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (O_CPU_ACK) act_q.push_back(ev_t'({cyc, 2'd0, O_CPU_DO}));
                if (O_SND_ACK) act_q.push_back(ev_t'({cyc, 2'd1, O_SND_DO}));
                if (O_WAV_ACK) act_q.push_back(ev_t'({cyc, 2'd2, O_WAV_DO}));
                if (!O_CPU_ACK && O_CPU_DO !== pdo[0]) glitch++;
                if (!O_SND_ACK && O_SND_DO !== pdo[1]) glitch++;
                if (!O_WAV_ACK && O_WAV_DO !== pdo[2]) glitch++;
                if (O_MEM_RD && !prd) act_a.push_back(O_MEM_A);
                if (O_MEM_RD && prd && O_MEM_A !== pa) glitch++;
                if (!O_MEM_RD && !prd && O_MEM_A !== 20'h0) glitch++;
            end
            pdo[0] = O_CPU_DO; pdo[1] = O_SND_DO; pdo[2] = O_WAV_DO;
            pa = O_MEM_A; prd = O_MEM_RD;
        end
    end

    // Timeline model: one transaction at a time, IDLE arbitration over
    // ports whose request landed in an earlier cycle, ACK at IDLE+2+w.
    task automatic model(input int n, input int base, input int dl[$]);
        bit          pend [3];
        logic [19:0] pa [3];
        int          cur, ack, di, p, w;
        cur = -1; ack = 0; di = 0;
        for (int q = 0; q < 3; q++) begin pend[q] = 0; pa[q] = '0; end
        for (int t = 0; t < n + 200; t++) begin
            if (cur < 0) begin
                p = -1;
                if (pend[0]) p = 0;
                else if (pend[1] && (!pend[2] || m_snd_next)) p = 1;
                else if (pend[2]) p = 2;
                if (p >= 0) begin
                    w = (di < dl.size()) ? dl[di] : 1;
                    di++;
                    cur = p;
                    ack = t + 2 + w;
                    exp_q.push_back(ev_t'({base + ack, 2'(p), mdata(pa[p])}));
                    exp_a.push_back(pa[p]);
                    if (p == 1) m_snd_next = 1'b0;
                    if (p == 2) m_snd_next = 1'b1;
                end
            end
            for (int q = 0; q < 3; q++)
                if (t < n && sreq[q][t] && !pend[q]) begin
                    pend[q] = 1;
                    pa[q]   = map(q, saddr[q][t]);
                end
            if (cur >= 0 && t == ack) begin
                pend[cur] = 0;
                cur = -1;
            end
        end
    endtask

    task automatic clear_sched();
        for (int q = 0; q < 3; q++)
            for (int t = 0; t < MAXC; t++) begin
                sreq[q][t]  = 1'b0;
                saddr[q][t] = 19'($urandom);
            end
    endtask

    task automatic run_sched(input int n, input bit fast);
        int dl[$];
        int last;
        exp_q.delete(); act_q.delete();
        exp_a.delete(); act_a.delete();
        glitch = 0;
        for (int k = 0; k < 128; k++)
            dl.push_back(fast ? 1 : $urandom_range(1, 3));
        dly_q = dl;
        @(negedge clk);
        sched_base = cyc;
        model(n, sched_base, dl);
        for (int t = 0; t < n; t++) begin
            if (t > 0) @(negedge clk);
            I_CPU_REQ = sreq[0][t]; I_CPU_A = saddr[0][t][15:0];
            I_SND_REQ = sreq[1][t]; I_SND_A = saddr[1][t][11:0];
            I_WAV_REQ = sreq[2][t]; I_WAV_A = saddr[2][t];
        end
        @(negedge clk);
        I_CPU_REQ = 1'b0; I_SND_REQ = 1'b0; I_WAV_REQ = 1'b0;
        last = (exp_q.size() > 0) ? exp_q[$].cyc : sched_base + n;
        while (cyc < last + 3) @(negedge clk);
        dly_q.delete();
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_chk++;
        if ({O_MEM_RD, O_MEM_A} !== 21'h0) begin
            n_fail++;
            $display("FAIL reset_mem actual rd=%b a=%h expected rd=0 a=0", O_MEM_RD, O_MEM_A);
        end
        n_chk++;
        if ({O_CPU_ACK, O_SND_ACK, O_WAV_ACK, O_TMO_ERR} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_ack actual %b%b%b tmo=%b expected 0", O_CPU_ACK, O_SND_ACK, O_WAV_ACK, O_TMO_ERR);
        end
        n_chk++;
        if ({O_CPU_DO, O_SND_DO, O_WAV_DO} !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_do actual %h %h %h expected 00", O_CPU_DO, O_SND_DO, O_WAV_DO);
        end
        rst_n = 1'b1;
        m_snd_next = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_cpu();
        int dt;
        clear_sched();
        sreq[0][0]  = 1'b1;
        saddr[0][0] = 19'h01234;
        force_do = 8'hA5;
        run_sched(4, 1'b1);
        force_do = -1;
        n_chk++;
        if (act_q.size() != 1) begin
            n_fail++;
            $display("FAIL single_count actual=%0d expected=1", act_q.size());
        end
        if (act_q.size() > 0) begin
            dt = act_q[0].cyc - sched_base;
            n_chk++;
            if (dt != 4 || act_q[0].port !== 2'd0 || act_q[0].data !== 8'hA5) begin
                n_fail++;
                $display("FAIL single_ack actual dt=%0d port=%0d do=%h expected dt=4 port=0 do=a5", dt, act_q[0].port, act_q[0].data);
            end
        end
        n_chk++;
        if (act_a.size() < 1 || act_a[0] !== 20'h01234) begin
            n_fail++;
            $display("FAIL single_addr actual n=%0d a=%h expected 01234", act_a.size(), (act_a.size() > 0) ? act_a[0] : 20'h0);
        end
        repeat (5) @(negedge clk);
        n_chk++;
        if (O_CPU_DO !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_hold actual=%h expected=a5", O_CPU_DO);
        end
    endtask

    task automatic test_same_cycle();
        int dt;
        clear_sched();
        for (int q = 0; q < 3; q++) sreq[q][0] = 1'b1;
        run_sched(1, 1'b1);
        n_chk++;
        if (act_q.size() != 3) begin
            n_fail++;
            $display("FAIL same_count actual=%0d expected=3", act_q.size());
        end
        for (int i = 0; i < 3; i++)
            if (i < act_q.size()) begin
                dt = act_q[i].cyc - sched_base;
                n_chk++;
                if (dt != 4 * (i + 1) || act_q[i].port !== 2'(i) ||
                    act_q[i].data !== mdata(map(i, saddr[i][0]))) begin
                    n_fail++;
                    $display("FAIL same_ack%0d actual dt=%0d port=%0d do=%h expected dt=%0d port=%0d do=%h",
                             i, dt, act_q[i].port, act_q[i].data, 4 * (i + 1), i, mdata(map(i, saddr[i][0])));
                end
            end
    endtask

    task automatic test_round_robin();
        int last_p;
        clear_sched();
        for (int t = 0; t < 80; t++) begin sreq[1][t] = 1'b1; sreq[2][t] = 1'b1; end
        sreq[0][21] = 1'b1;
        run_sched(80, 1'b0);
        n_chk++;
        if (act_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL rr_count actual=%0d expected=%0d", act_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < act_q.size()) begin
            n_chk++;
            if (act_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL rr_ack%0d actual cyc=%0d port=%0d do=%h expected cyc=%0d port=%0d do=%h",
                         i, act_q[i].cyc, act_q[i].port, act_q[i].data, exp_q[i].cyc, exp_q[i].port, exp_q[i].data);
            end
        end
        last_p = -1;
        foreach (act_q[i]) if (act_q[i].port != 2'd0) begin
            n_chk++;
            if (int'(act_q[i].port) == last_p) begin
                n_fail++;
                $display("FAIL rr_alternate ack%0d actual port=%0d expected port!=%0d", i, act_q[i].port, last_p);
            end
            last_p = int'(act_q[i].port);
        end
        n_chk++;
        if (glitch != 0) begin
            n_fail++;
            $display("FAIL rr_stability actual=%0d expected=0", glitch);
        end
    endtask

    task automatic test_addr_boundary();
        clear_sched();
        sreq[2][0] = 1'b1; saddr[2][0] = 19'h7FFFF;
        sreq[1][3] = 1'b1; saddr[1][3] = 19'h00FFF;
        run_sched(4, 1'b0);
        n_chk++;
        if (act_a.size() != 2 || act_a[0] !== 20'hFFFFF || act_a[1] !== 20'h10FFF) begin
            n_fail++;
            $display("FAIL bound_addr actual n=%0d a0=%h a1=%h expected fffff 10fff", act_a.size(),
                     (act_a.size() > 0) ? act_a[0] : 20'h0, (act_a.size() > 1) ? act_a[1] : 20'h0);
        end
        foreach (exp_q[i]) begin
            n_chk++;
            if (i >= act_q.size() || act_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL bound_ack%0d actual n=%0d expected cyc=%0d port=%0d do=%h",
                         i, act_q.size(), exp_q[i].cyc, exp_q[i].port, exp_q[i].data);
            end
        end
    endtask

    task automatic test_random();
        clear_sched();
        for (int q = 0; q < 3; q++)
            for (int t = 0; t < 400; t++)
                sreq[q][t] = ($urandom_range(0, 9) == 0);
        run_sched(400, 1'b0);
        n_chk++;
        if (act_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL rand_count actual=%0d expected=%0d", act_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < act_q.size()) begin
            n_chk++;
            if (act_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL rand_ack%0d actual cyc=%0d port=%0d do=%h expected cyc=%0d port=%0d do=%h",
                         i, act_q[i].cyc, act_q[i].port, act_q[i].data, exp_q[i].cyc, exp_q[i].port, exp_q[i].data);
            end
        end
        foreach (exp_a[i]) begin
            n_chk++;
            if (i >= act_a.size() || act_a[i] !== exp_a[i]) begin
                n_fail++;
                $display("FAIL rand_addr%0d actual n=%0d expected a=%h", i, act_a.size(), exp_a[i]);
            end
        end
        n_chk++;
        if (glitch != 0) begin
            n_fail++;
            $display("FAIL rand_stability actual=%0d expected=0", glitch);
        end
    endtask

    task automatic test_timeout();
        int base;
        act_q.delete(); dly_q.delete();
        @(negedge clk);
        base = cyc;
        I_CPU_REQ = 1'b1; I_CPU_A = 16'h0BEE;
        @(negedge clk);
        I_CPU_REQ = 1'b0;
        repeat (TMO + 12) @(negedge clk);
`ifdef DKONG_ROM_ARB_TIMEOUT_EN
        n_chk++;
        if (act_q.size() != 1 || act_q[0].cyc != base + 3 + TMO ||
            act_q[0].port !== 2'd0 || act_q[0].data !== 8'hFF) begin
            n_fail++;
            $display("FAIL tmo_ack actual n=%0d cyc=%0d do=%h expected n=1 cyc=%0d do=ff", act_q.size(),
                     (act_q.size() > 0) ? act_q[0].cyc : -1, (act_q.size() > 0) ? act_q[0].data : 8'h0, base + 3 + TMO);
        end
        n_chk++;
        if (O_TMO_ERR !== 1'b1 || O_MEM_RD !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_err actual err=%b rd=%b expected err=1 rd=0", O_TMO_ERR, O_MEM_RD);
        end
        repeat (10) @(negedge clk);
        n_chk++;
        if (O_TMO_ERR !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_sticky actual=%b expected=1", O_TMO_ERR);
        end
`else
        n_chk++;
        if (act_q.size() != 0 || O_MEM_RD !== 1'b1 || O_TMO_ERR !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_hold actual n=%0d rd=%b err=%b expected n=0 rd=1 err=0", act_q.size(), O_MEM_RD, O_TMO_ERR);
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_snd_next = 1'b1;
        repeat (2) @(negedge clk);
`endif
    endtask

    task automatic test_reset_mid();
        int base;
        act_q.delete(); dly_q.delete();
        @(negedge clk);
        base = cyc;
        I_CPU_REQ = 1'b1; I_CPU_A = 16'h4321;
        @(negedge clk);
        I_CPU_REQ = 1'b0;
        while (cyc < base + 5) @(negedge clk);
        n_chk++;
        if (O_MEM_RD !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_inwait actual rd=%b expected 1", O_MEM_RD);
        end
        #5 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({O_MEM_RD, O_MEM_A, O_CPU_ACK, O_SND_ACK, O_WAV_ACK, O_TMO_ERR} !== 25'h0 ||
            {O_CPU_DO, O_SND_DO, O_WAV_DO} !== 24'h0) begin
            n_fail++;
            $display("FAIL mid_async actual rd=%b a=%h err=%b do=%h%h%h expected all 0",
                     O_MEM_RD, O_MEM_A, O_TMO_ERR, O_CPU_DO, O_SND_DO, O_WAV_DO);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_snd_next = 1'b1;
        repeat (20) @(negedge clk);
        n_chk++;
        if (act_q.size() != 0 || O_MEM_RD !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_noack actual n=%0d rd=%b expected n=0 rd=0", act_q.size(), O_MEM_RD);
        end
        clear_sched();
        sreq[1][0] = 1'b1;
        sreq[2][0] = 1'b1;
        run_sched(1, 1'b1);
        foreach (exp_q[i]) begin
            n_chk++;
            if (i >= act_q.size() || act_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL mid_after%0d actual n=%0d expected cyc=%0d port=%0d do=%h",
                         i, act_q.size(), exp_q[i].cyc, exp_q[i].port, exp_q[i].data);
            end
        end
        n_chk++;
        if (act_q.size() < 1 || act_q[0].port !== 2'd1) begin
            n_fail++;
            $display("FAIL mid_sndfirst actual n=%0d port=%0d expected port=1", act_q.size(),
                     (act_q.size() > 0) ? act_q[0].port : 2'd3);
        end
    endtask

    initial begin
        clear_sched();
        test_reset();
        test_single_cpu();
        test_same_cycle();
        test_round_robin();
        test_addr_boundary();
        test_random();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
